// File: rtl/sliding_window_3x3.sv
// 3x3 raster sliding window built from two line delays and a shifting register array.
// Optional macro SLIDING_WINDOW_COORD_EN adds window-centre coordinate outputs win_x/win_y.
module sliding_window_3x3 #(
    parameter int unsigned IMG_W = 480,
    parameter int unsigned IMG_H = 360,
    parameter int unsigned PIX_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    input  logic               sof,
    output logic [9*PIX_W-1:0] win_out,
    output logic               win_valid,
    output logic               frame_done
`ifdef SLIDING_WINDOW_COORD_EN
    ,
    output logic [$clog2(IMG_W)-1:0] win_x,
    output logic [$clog2(IMG_H)-1:0] win_y
`endif
);

    localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);
    localparam logic [CW-1:0] ColTwo  = CW'(2);
    localparam logic [RW-1:0] RowTwo  = RW'(2);

    typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      col_q, col_d, cur_col;
    logic [RW-1:0]      row_q, row_d, cur_row;
    logic               accept, last_pix;
    logic               win_valid_q, win_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [9*PIX_W-1:0] win_q, win_d;
    logic [3*PIX_W-1:0] new_col;
    logic [PIX_W-1:0]   ld1_q [IMG_W];
    logic [PIX_W-1:0]   ld2_q [IMG_W];

    // A sof pixel always restarts the frame at (0,0), even mid-frame.
    always_comb begin
        accept   = pix_valid && (sof || (state_q != StIdle));
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        last_pix = (cur_row == RowLast) && (cur_col == ColLast);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (accept) begin
            if (sof) begin
                state_d = StFill;
            end else if (last_pix) begin
                state_d = StIdle;
            end else if ((state_q == StFill) && (cur_row == RowTwo) && (cur_col == '0)) begin
                state_d = StRun;
            end
        end
    end

    always_comb begin
        win_valid_d  = accept && (cur_row >= RowTwo) && (cur_col >= ColTwo);
        frame_done_d = accept && last_pix;
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == ColLast) begin
                col_d = '0;
                row_d = (cur_row == RowLast) ? '0 : cur_row + RW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // Row r of the incoming column sits at new_col[PIX_W*r +: PIX_W]; r=0 is the oldest line.
    always_comb begin
        new_col = {pix_in, ld1_q[IMG_W-1], ld2_q[IMG_W-1]};
        win_d   = win_q;
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win_d[PIX_W*(3*r)   +: PIX_W] = win_q[PIX_W*(3*r+1) +: PIX_W];
                win_d[PIX_W*(3*r+1) +: PIX_W] = win_q[PIX_W*(3*r+2) +: PIX_W];
                win_d[PIX_W*(3*r+2) +: PIX_W] = new_col[PIX_W*r +: PIX_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            win_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_q        <= win_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Line delays carry no reset; stale contents are flushed before any window uses them.
    always_ff @(posedge clk) begin
        if (accept) begin
            ld1_q[0] <= pix_in;
            ld2_q[0] <= ld1_q[IMG_W-1];
            for (int i = 1; i < int'(IMG_W); i++) begin
                ld1_q[i] <= ld1_q[i-1];
                ld2_q[i] <= ld2_q[i-1];
            end
        end
    end

    assign win_out    = win_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

`ifdef SLIDING_WINDOW_COORD_EN
    logic [CW-1:0] win_x_q;
    logic [RW-1:0] win_y_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_x_q <= '0;
            win_y_q <= '0;
        end else if (accept) begin
            win_x_q <= cur_col - CW'(1);
            win_y_q <= cur_row - RW'(1);
        end
    end

    assign win_x = win_x_q;
    assign win_y = win_y_q;
`endif

endmodule

// File: tb/tb_sliding_window_3x3.sv
// Scoreboard bench for sliding_window_3x3: a frame-array reference model queues expected
// windows and frame_done pulses; a negedge monitor pops and compares them.
module tb_sliding_window_3x3;

    localparam int W  = 5;
    localparam int H  = 4;
    localparam int PW = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              pix_valid = 1'b0;
    logic              sof = 1'b0;
    logic [PW-1:0]     pix_in = '0;
    logic [9*PW-1:0]   win_out;
    logic              win_valid;
    logic              frame_done;
`ifdef SLIDING_WINDOW_COORD_EN
    logic [2:0]        win_x;
    logic [1:0]        win_y;
`endif

    sliding_window_3x3 #(
        .IMG_W (W),
        .IMG_H (H),
        .PIX_W (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .sof        (sof),
        .win_out    (win_out),
        .win_valid  (win_valid),
        .frame_done (frame_done)
`ifdef SLIDING_WINDOW_COORD_EN
        ,
        .win_x      (win_x),
        .win_y      (win_y)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            cyc;
        logic [9*PW-1:0] win;
        int            x;
        int            y;
    } exp_t;

    exp_t          exp_win_q[$];
    int            exp_done_q[$];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;

    logic [PW-1:0] img [H][W];
    bit            m_active = 1'b0;
    int            m_row = 0;
    int            m_col = 0;
    bit            drv_acc = 1'b0, drv_rst = 1'b0;
    bit            samp_acc = 1'b0, samp_rst = 1'b0;
    logic [9*PW-1:0] prev_win = '0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        samp_acc <= drv_acc;
        samp_rst <= drv_rst;
    end

    task automatic check_w(input string name, input logic [9*PW-1:0] act,
                           input logic [9*PW-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h required %0h", name, cyc, act, req);
        end
    endtask

    task automatic check_s(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d required %0d", name, cyc, act, req);
        end
    endtask

    function automatic logic [PW-1:0] pv(input int r, input int c);
        return PW'(10 * r + c + 1);
    endfunction

    // Drive one cycle of inputs and advance the reference model by one pixel.
    task automatic drive(input bit v, input bit s, input logic [PW-1:0] p, input bit r);
        exp_t e;
        @(posedge clk);
        #1;
        pix_valid = v;
        sof       = s;
        pix_in    = p;
        rst_n     = r;
        drv_rst   = r;
        drv_acc   = 1'b0;
        if (!r) begin
            m_active = 1'b0;
            m_row    = 0;
            m_col    = 0;
        end else if (v && (s || m_active)) begin
            drv_acc = 1'b1;
            if (s) begin
                m_active = 1'b1;
                m_row    = 0;
                m_col    = 0;
            end
            img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) begin
                e.cyc = cyc + 1;
                e.x   = m_col - 1;
                e.y   = m_row - 1;
                e.win = '0;
                for (int rr = 0; rr < 3; rr++)
                    for (int cc = 0; cc < 3; cc++)
                        e.win[PW*(3*rr+cc) +: PW] = img[m_row-2+rr][m_col-2+cc];
                exp_win_q.push_back(e);
            end
            if (m_row == H - 1 && m_col == W - 1) begin
                exp_done_q.push_back(cyc + 1);
                m_active = 1'b0;
                m_row    = 0;
                m_col    = 0;
            end else if (m_col == W - 1) begin
                m_col = 0;
                m_row++;
            end else begin
                m_col++;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic frame_pat(input bit gaps);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                drive(1'b1, (r == 0 && c == 0), pv(r, c), 1'b1);
                if (gaps) drive(1'b0, 1'b0, '0, 1'b1);
            end
        end
        idle(2);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (win_valid === 1'b1) begin
            if (exp_win_q.size() == 0) begin
                check_s("spurious_win_valid", 32'(win_valid), 32'd0);
            end else begin
                e = exp_win_q.pop_front();
                check_s("win_cycle", cyc, e.cyc);
                check_w("win_out", win_out, e.win);
`ifdef SLIDING_WINDOW_COORD_EN
                check_s("win_x", {29'd0, win_x}, e.x);
                check_s("win_y", {30'd0, win_y}, e.y);
`endif
            end
        end
        if (frame_done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                check_s("spurious_frame_done", 32'(frame_done), 32'd0);
            end else begin
                check_s("frame_done_cycle", cyc, exp_done_q.pop_front());
            end
        end
        if (samp_rst && !samp_acc) check_w("win_hold", win_out, prev_win);
        prev_win = win_out;
    end

    initial begin
        bit v, s, r;
        // Reset state
        drive(1'b1, 1'b1, 16'h1234, 1'b0);
        drive(1'b0, 1'b0, '0, 1'b0);
        @(negedge clk);
        check_s("rst_win_valid", {31'd0, win_valid}, 32'd0);
        check_s("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check_w("rst_win_out", win_out, '0);
        idle(2);

        // Continuous frame, then gapped frame
        frame_pat(1'b0);
        frame_pat(1'b1);

        // Pixels without sof while idle are ignored
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, PW'($urandom), 1'b1);
        frame_pat(1'b0);

        // Abort at row 2, col 3 by a fresh sof
        for (int i = 0; i <= 2 * W + 3; i++) drive(1'b1, i == 0, pv(i / W, i % W), 1'b1);
        frame_pat(1'b0);

        // Reset at row 3, col 1 takes priority over a valid pixel
        for (int i = 0; i <= 3 * W; i++) drive(1'b1, i == 0, pv(i / W, i % W), 1'b1);
        drive(1'b1, 1'b0, pv(3, 1), 1'b0);
        @(negedge clk);
        check_s("midrst_win_valid", {31'd0, win_valid}, 32'd0);
        check_s("midrst_frame_done", {31'd0, frame_done}, 32'd0);
        for (int c = 2; c < W; c++) drive(1'b1, 1'b0, pv(3, c), 1'b1);
        idle(1);
        frame_pat(1'b0);

        // Randomized traffic with gaps, stray pixels, aborts and rare resets
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 9) < 7);
            s = v && (m_active ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 3) == 0));
            r = ($urandom_range(0, 499) != 0);
            drive(v, s, PW'($urandom), r);
        end
        idle(5);

        check_s("win_queue_empty", exp_win_q.size(), 32'd0);
        check_s("done_queue_empty", exp_done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sliding_window_3x3.md
SLIDING_WINDOW_3X3 -- requirements
Module: sliding_window_3x3

Interface
REQ-001 SHALL have parameter IMG_W, default 480: pixels per line; also the line-delay depth.
REQ-002 SHALL have parameter IMG_H, default 360: lines per frame.
REQ-003 SHALL have parameter PIX_W, default 16: pixel width in bits.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1: synchronous, active-low reset, sampled on clk rising edge.
REQ-006 SHALL have port pix_in  input  PIX_W: raster-order pixel, same format as the line shift chain's data_in.
REQ-007 SHALL have port pix_valid  input  1: pix_in is accepted on each cycle this is high.
REQ-008 SHALL have port sof  input  1: start of frame, qualified by pix_valid; marks the pixel at row 0, col 0.
REQ-009 SHALL have port win_out  output  9*PIX_W: 3x3 window; element (r,c) at bits [PIX_W*(3r+c) +: PIX_W]; r=0 top/oldest line, c=0 leftmost/oldest column.
REQ-010 SHALL have port win_valid  output  1: win_out holds a complete, in-frame window.
REQ-011 SHALL have port frame_done  output  1: one-cycle pulse after the last pixel of a frame is accepted.

Function
REQ-012 SHALL hold two internal line delays of IMG_W entries each, advancing only on cycles with pix_valid high (never free-running).
REQ-013 SHALL hold a 3x3 register array that shifts left by one column on each accepted pixel; new column = {line-delay-2 out, line-delay-1 out, pix_in}.
REQ-014 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) for the accepted pixel.
REQ-015 SHALL implement states IDLE, FILL, RUN: IDLE->FILL on pix_valid&sof; FILL->RUN when an accepted pixel has row=2, col=0; RUN->IDLE after accepting row=IMG_H-1, col=IMG_W-1.
REQ-016 SHALL ignore pix_valid pixels without sof in IDLE: no counter, line-delay or window update.
REQ-017 SHALL, on accepted pixel at (row,col), update win_out and win_valid on the next rising edge (latency 1 cycle); bottom-right element (2,2) equals that pixel.
REQ-018 SHALL assert win_valid for exactly one cycle per accepted pixel with row>=2 and col>=2; deasserted otherwise, including idle cycles.
REQ-019 SHALL wrap col from IMG_W-1 to 0 and increment row; the first two columns of each line SHALL NOT produce win_valid (no cross-line windows).
REQ-020 SHALL pulse frame_done on the same edge that registers the window of the last pixel of the frame.
REQ-021 SHALL, on pix_valid&sof in FILL or RUN, abort the current frame: treat that pixel as row 0, col 0, enter FILL, no frame_done pulse.
REQ-022 SHALL hold win_out stable whenever pix_valid is low.

Reset
REQ-023 SHALL, with rst_n low at a rising edge, set state IDLE, row=0, col=0, win_valid=0, frame_done=0, win_out=0.
REQ-024 SHALL give reset priority over pix_valid and sof in the same cycle, including mid-frame.
REQ-025 SHALL NOT require line-delay contents to be cleared; they are never exposed before refill in FILL.

Configuration
REQ-026 SHALL, with macro SLIDING_WINDOW_COORD_EN defined, add outputs win_x (clog2(IMG_W) bits) and win_y (clog2(IMG_H) bits) giving the window-centre coordinates (col-1, row-1), registered with win_out, reset to 0.
REQ-027 SHALL, without SLIDING_WINDOW_COORD_EN, omit win_x/win_y ports and their logic; all other behaviour identical.

Verification (IMG_W=5, IMG_H=4, pixel value = 10*row+col+1)
REQ-028 SHALL cover full frame, pix_valid constant high from sof -> win_valid exactly 6 times; first window bottom-right=23, top-left=1, centre=12; frame_done once, cycle after the pixel 35 edge.
REQ-029 SHALL cover pix_valid toggled every other cycle -> same 6 windows, same values, win_out unchanged in gap cycles.
REQ-030 SHALL cover pixels without sof in IDLE, then sof -> no win_valid before sof; frame result as REQ-028.
REQ-031 SHALL cover sof reasserted at row 2, col 3 -> no frame_done for aborted frame; next win_valid only at new row 2, col 2.
REQ-032 SHALL cover rst_n low one cycle at row 3, col 1 -> next edge win_valid=0, frame_done=0, state IDLE; later pixels ignored until sof.
REQ-033 SHALL cover with SLIDING_WINDOW_COORD_EN, REQ-028 stimulus -> (win_x,win_y) sequence (1,1),(2,1),(3,1),(1,2),(2,2),(3,2).
